display_scan_mux: RTL and testbench

Time-multiplexed N-channel scan multiplexer for common-anode seven-segment digit banks. It is the sequential successor to the combinational 4:1 selector. It cycles through CHANNELS parallel data words, presenting one at a time on a registered output with a matching active-low digit strobe. A programmable blanking gap between digits suppresses ghosting. A manual mode holds a single chosen channel. It sits between the segment encoders and the board's segment and anode pins.

---
 rtl/display_scan_mux.sv | 148 ++++++++++++++
 tb/tb_display_scan_mux.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// Time-multiplexed scan driver for common-anode seven-segment banks.
// Each channel is shown for DWELL cycles with a BLANK-cycle dark gap between digits.
module display_scan_mux #(
    parameter int DATA_WIDTH = 7,
    parameter int CHANNELS   = 4,
    parameter int DWELL      = 50000,
    parameter int BLANK      = 2,
    localparam int SEL_W     = $clog2(CHANNELS)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic                           enable,
    input  logic                           mode,
    input  logic [SEL_W-1:0]               manual_select,
    output logic [DATA_WIDTH-1:0]          out,
    output logic [CHANNELS-1:0]            digit_select,
    output logic [SEL_W-1:0]               channel,
    output logic                           scan_wrap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_SHOW
    } state_t;

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CHANNELS - 1);
    // With no blanking gap a finished digit goes straight to the next SHOW.
    localparam state_t AFTER_SHOW = (BLANK == 0) ? S_SHOW : S_GAP;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [SEL_W-1:0]      r_chan;
    logic [DATA_WIDTH-1:0] r_out;
    logic [CHANNELS-1:0]   r_digit;
    logic                  r_wrap;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [SEL_W-1:0]      w_chan_nxt;
    logic                  w_wrap_nxt;
    logic [SEL_W-1:0]      w_msel;
    logic [SEL_W-1:0]      w_chan_adv;
    logic [DATA_WIDTH-1:0] w_data;
    logic [CHANNELS-1:0]   w_strobe;
    logic [DATA_WIDTH-1:0] w_words [CHANNELS];

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_words
        assign w_words[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        w_msel = manual_select;
        if (int'(manual_select) > CHANNELS - 1) begin
            w_msel = LAST_CH;
        end
    end

    assign w_chan_adv = (r_chan == LAST_CH) ? '0 : r_chan + SEL_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_chan_nxt  = r_chan;
        w_wrap_nxt  = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_chan_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = AFTER_SHOW;
                    w_cnt_nxt   = '0;
                    w_chan_nxt  = mode ? w_msel : '0;
                end
                S_GAP: begin
                    if (mode) begin
                        w_chan_nxt = w_msel;
                    end
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = S_SHOW;
                        w_cnt_nxt   = '0;
                    end
                end
                S_SHOW: begin
                    if (mode && (w_msel != r_chan)) begin
                        // A new manual pick cuts the dwell short and blanks first.
                        w_state_nxt = AFTER_SHOW;
                        w_cnt_nxt   = '0;
                        w_chan_nxt  = w_msel;
                    end else if (r_cnt == DWELL_LAST) begin
                        w_state_nxt = AFTER_SHOW;
                        w_cnt_nxt   = '0;
                        if (!mode) begin
                            w_chan_nxt = w_chan_adv;
                            w_wrap_nxt = (r_chan == LAST_CH);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_chan_nxt  = '0;
                end
            endcase
        end
    end

    // Output stage: drive segments and strobe from the state held this cycle.
    always_comb begin
        w_strobe = '1;
        w_data   = '0;
        if (r_state == S_SHOW) begin
            w_strobe[r_chan] = 1'b0;
            w_data           = w_words[r_chan];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_chan  <= '0;
            r_out   <= '0;
            r_digit <= '1;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chan  <= w_chan_nxt;
            r_out   <= w_data;
            r_digit <= w_strobe;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign out          = r_out;
    assign digit_select = r_digit;
    assign channel      = r_chan;
    assign scan_wrap    = r_wrap;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: three parameterisations driven from a vector table
// through an expected-value queue, plus hand-written reset sequences.
module tb_display_scan_mux;

    typedef struct {
        int         dut;
        logic       en;
        logic       md;
        logic [1:0] ms;
        logic [6:0] w1;
        logic [6:0] eout;
        logic [3:0] edig;
        logic [1:0] ech;
        logic       ewrap;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // dut_a: 4 channels, DWELL 4, BLANK 1
    logic        en_a = 1'b0, md_a = 1'b0;
    logic [1:0]  ms_a = '0;
    logic [27:0] din_a = {7'h44, 7'h33, 7'h22, 7'h11};
    logic [6:0]  out_a;
    logic [3:0]  dig_a;
    logic [1:0]  ch_a;
    logic        wrap_a;

    // dut_b: 3 channels, DWELL 2, BLANK 1 (manual clamp)
    logic        en_b = 1'b0, md_b = 1'b0;
    logic [1:0]  ms_b = '0;
    logic [20:0] din_b = {7'h0C, 7'h0B, 7'h0A};
    logic [6:0]  out_b;
    logic [2:0]  dig_b;
    logic [1:0]  ch_b;
    logic        wrap_b;

    // dut_c: 4 channels, DWELL 1, BLANK 0
    logic        en_c = 1'b0, md_c = 1'b0;
    logic [1:0]  ms_c = '0;
    logic [27:0] din_c = {7'h44, 7'h33, 7'h22, 7'h11};
    logic [6:0]  out_c;
    logic [3:0]  dig_c;
    logic [1:0]  ch_c;
    logic        wrap_c;

    display_scan_mux #(.DATA_WIDTH(7), .CHANNELS(4), .DWELL(4), .BLANK(1)) dut_a (
        .clock(clk), .reset_n(reset_n), .in_data(din_a), .enable(en_a), .mode(md_a),
        .manual_select(ms_a), .out(out_a), .digit_select(dig_a), .channel(ch_a),
        .scan_wrap(wrap_a)
    );

    display_scan_mux #(.DATA_WIDTH(7), .CHANNELS(3), .DWELL(2), .BLANK(1)) dut_b (
        .clock(clk), .reset_n(reset_n), .in_data(din_b), .enable(en_b), .mode(md_b),
        .manual_select(ms_b), .out(out_b), .digit_select(dig_b), .channel(ch_b),
        .scan_wrap(wrap_b)
    );

    display_scan_mux #(.DATA_WIDTH(7), .CHANNELS(4), .DWELL(1), .BLANK(0)) dut_c (
        .clock(clk), .reset_n(reset_n), .in_data(din_c), .enable(en_c), .mode(md_c),
        .manual_select(ms_c), .out(out_c), .digit_select(dig_c), .channel(ch_c),
        .scan_wrap(wrap_c)
    );

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t sb[$];

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [6:0] word_of(input int dut, input int ch, input logic [6:0] w1);
        logic [6:0] w;
        w = 7'h00;
        if (dut == 1) begin
            case (ch)
                0: w = 7'h0A;
                1: w = 7'h0B;
                default: w = 7'h0C;
            endcase
        end else begin
            case (ch)
                0: w = 7'h11;
                1: w = (dut == 0) ? w1 : 7'h22;
                2: w = 7'h33;
                default: w = 7'h44;
            endcase
        end
        return w;
    endfunction

    // Shown channel for dut_a after edge e of a run (-1 = dark): 1 gap + 4 dwell per digit.
    function automatic int disp_a(input int e);
        if (e == 0 || (e - 1) % 5 == 0) return -1;
        return ((e - 2) / 5) % 4;
    endfunction

    task automatic add(input int dut, input logic en, input logic md, input logic [1:0] ms,
                       input logic [6:0] w1, input int shown, input int ch, input logic wrap);
        vec_t v;
        v.dut  = dut;
        v.en   = en;
        v.md   = md;
        v.ms   = ms;
        v.w1   = w1;
        v.eout = (shown < 0) ? 7'h00 : word_of(dut, shown, w1);
        v.edig = (shown < 0) ? 4'hF : (4'hF & ~(4'd1 << shown));
        v.ech  = 2'(ch);
        v.ewrap = wrap;
        vecs.push_back(v);
    endtask

    task automatic dark_a(input string nm);
        @(posedge clk);
        #1;
        check({nm, "_out"}, -1, 32'(out_a), 32'h0);
        check({nm, "_dig"}, -1, 32'(dig_a), 32'hF);
        check({nm, "_ch"},  -1, 32'(ch_a),  32'h0);
    endtask

    initial begin
        vec_t v;
        vec_t x;
        logic [6:0] ao;
        logic [3:0] ad;
        logic [1:0] ac;
        logic       aw;

        // BLANK=0, DWELL=1: one channel per cycle, no dark cycles after start.
        for (int e = 0; e <= 9; e++)
            add(2, 1'b1, 1'b0, 2'd0, 7'h22, (e == 0) ? -1 : (e - 1) % 4, e % 4,
                (e > 0) && (e % 4 == 0));
        // Manual select 3 on a 3-channel bank clamps to channel 2.
        for (int e = 0; e <= 6; e++)
            add(1, 1'b1, 1'b1, 2'd3, 7'h22, (e == 0 || (e - 1) % 3 == 0) ? -1 : 2, 2, 1'b0);
        // Auto scan; channel 1 word changes before edge 8 (its second SHOW cycle).
        for (int e = 0; e <= 33; e++)
            add(0, 1'b1, 1'b0, 2'd0, (e >= 8) ? 7'h5A : 7'h22, disp_a(e), (e / 5) % 4, e == 20);
        add(0, 1'b0, 1'b0, 2'd0, 7'h5A, disp_a(34), 0, 1'b0);
        for (int i = 0; i < 3; i++) add(0, 1'b0, 1'b0, 2'd0, 7'h5A, -1, 0, 1'b0);
        // Re-enable restarts from channel 0 after the gap.
        for (int e = 0; e <= 7; e++)
            add(0, 1'b1, 1'b0, 2'd0, 7'h5A, disp_a(e), (e / 5) % 4, 1'b0);
        add(0, 1'b0, 1'b0, 2'd0, 7'h5A, disp_a(8), 0, 1'b0);
        add(0, 1'b0, 1'b0, 2'd0, 7'h5A, -1, 0, 1'b0);
        // Manual hold on channel 2, then switch to 1 mid-SHOW at edge 13.
        for (int e = 0; e <= 12; e++)
            add(0, 1'b1, 1'b1, 2'd2, 7'h5A, (disp_a(e) < 0) ? -1 : 2, 2, 1'b0);
        for (int e = 13; e <= 20; e++)
            add(0, 1'b1, 1'b1, 2'd1, 7'h5A, (e == 13) ? 2 : ((e == 14 || e == 19) ? -1 : 1),
                1, 1'b0);

        // Reset held across edges, then released with everything disabled.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", -1, 32'(out_a), 32'h0);
        check("rst_dig", -1, 32'(dig_a), 32'hF);
        check("rst_ch", -1, 32'(ch_a), 32'h0);
        check("rst_wrap", -1, 32'(wrap_a), 32'h0);
        check("rst_dig_b", -1, 32'(dig_b), 32'h7);
        reset_n = 1'b1;
        repeat (3) dark_a("idle");

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            case (v.dut)
                0: begin
                    en_a = v.en; md_a = v.md; ms_a = v.ms;
                    din_a = {7'h44, 7'h33, v.w1, 7'h11};
                end
                1: begin en_b = v.en; md_b = v.md; ms_b = v.ms; end
                default: begin en_c = v.en; md_c = v.md; ms_c = v.ms; end
            endcase
            sb.push_back(v);
            @(posedge clk);
            #1;
            x = sb.pop_front();
            case (x.dut)
                0: begin ao = out_a; ad = dig_a; ac = ch_a; aw = wrap_a; end
                1: begin ao = out_b; ad = {1'b1, dig_b}; ac = ch_b; aw = wrap_b; end
                default: begin ao = out_c; ad = dig_c; ac = ch_c; aw = wrap_c; end
            endcase
            check("out", i, 32'(ao), 32'(x.eout));
            check("dig", i, 32'(ad), 32'(x.edig));
            check("ch", i, 32'(ac), 32'(x.ech));
            check("wrap", i, 32'(aw), 32'(x.ewrap));
        end

        // Asynchronous reset in the middle of a SHOW on channel 1.
        check("pre_rst_dig", -1, 32'(dig_a), 32'hD);
        #2 reset_n = 1'b0;
        #1;
        check("async_out", -1, 32'(out_a), 32'h0);
        check("async_dig", -1, 32'(dig_a), 32'hF);
        check("async_ch", -1, 32'(ch_a), 32'h0);
        en_a = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) dark_a("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
